// File: rtl/polar_sector_mapper.sv
// Maps CORDIC atan2/magnitude results to a Q0.32 turn fraction and sector index, buffered in a FWFT FIFO.
// Optional radius clamp enabled by defining POLAR_MAPPER_RCLAMP_EN.
module polar_sector_mapper #(
  parameter int          SECTOR_BITS = 3,
  parameter int          DEPTH       = 8,
  parameter logic [64:0] R_MAX       = 65'd16 << 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [64:0]              in_atan2,
  input  logic [64:0]              in_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_turn,
  output logic [SECTOR_BITS-1:0]   out_sector,
  output logic [64:0]              out_r,
  output logic                     out_r_clamped,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [64:0] TWO_PI  = 65'h6487ED511;
  localparam logic [31:0] INV_2PI = 32'h28BE60DC;

  logic        v1_q, v2_q, v3_q;
  logic [34:0] a1_q, a1_d;
  logic [64:0] r1_q, r2_q, r3_q, r3_d;
  logic [66:0] p2_q, p2_d;
  logic [31:0] t3_q, t3_d;
  logic        c3_q, c3_d;
  logic [64:0] sum;
  logic        unused_bits;

  // Negative angles are lifted by 2*pi; anything still negative is pinned to 0.
  always_comb begin
    sum  = in_atan2 + TWO_PI;
    a1_d = in_atan2[34:0];
    if (in_atan2[64]) a1_d = sum[64] ? '0 : sum[34:0];
  end

  assign p2_d = {32'd0, a1_q} * {35'd0, INV_2PI};
  assign t3_d = (|p2_q[66:64]) ? 32'hFFFFFFFF : p2_q[63:32];

`ifdef POLAR_MAPPER_RCLAMP_EN
  always_comb begin
    c3_d = $signed(r2_q) > $signed(R_MAX);
    r3_d = c3_d ? R_MAX : r2_q;
  end
  assign unused_bits = ^{sum[63:35], in_atan2[63:35], p2_q[31:0]};
`else
  assign c3_d        = 1'b0;
  assign r3_d        = r2_q;
  assign unused_bits = ^{sum[63:35], in_atan2[63:35], p2_q[31:0], R_MAX};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      a1_q <= '0;   r1_q <= '0;
      p2_q <= '0;   r2_q <= '0;
      t3_q <= '0;   r3_q <= '0;   c3_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
      a1_q <= a1_d;
      r1_q <= in_r;
      v2_q <= v1_q;
      p2_q <= p2_d;
      r2_q <= r1_q;
      v3_q <= v2_q;
      t3_q <= t3_d;
      r3_q <= r3_d;
      c3_q <= c3_d;
    end
  end

  // Output handshake: the head entry transfers on any edge where out_valid && out_ready;
  // while out_valid && !out_ready the head data is held stable.
  logic [31:0] mem_t [DEPTH];
  logic [64:0] mem_r [DEPTH];
  logic        mem_c [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          pop, full, accept, drop;

  assign pop    = out_valid && out_ready;
  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign accept = v3_q && (!full || pop);
  assign drop   = v3_q && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_t[i] <= '0;
        mem_r[i] <= '0;
        mem_c[i] <= 1'b0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_t[wr_q] <= t3_q;
        mem_r[wr_q] <= r3_q;
        mem_c[wr_q] <= c3_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid     = (cnt_q != '0);
  assign out_turn      = mem_t[rd_q];
  assign out_sector    = out_turn[31 -: SECTOR_BITS];
  assign out_r         = mem_r[rd_q];
  assign out_r_clamped = mem_c[rd_q];
  assign level         = cnt_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_polar_sector_mapper.sv
// Directed bench for polar_sector_mapper: value-level model of pipeline + FIFO, per-cycle compare, literal pins.
module tb_polar_sector_mapper;
  localparam int          DEPTH = 4;
  localparam int          W     = 98;
  localparam logic [64:0] R_MAX = 65'd16 << 32;
  localparam logic [64:0] R_3P5 = 65'h3_80000000;
  localparam logic [64:0] R_20  = 65'h14_00000000;

  logic        clk, rst_n, in_valid, out_valid, out_ready, out_r_clamped, overflow, ovf_clr;
  logic [64:0] in_atan2, in_r, out_r;
  logic [31:0] out_turn;
  logic [2:0]  out_sector;
  logic [2:0]  level;

  polar_sector_mapper #(.SECTOR_BITS(3), .DEPTH(DEPTH), .R_MAX(R_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_atan2(in_atan2), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_turn(out_turn), .out_sector(out_sector),
    .out_r(out_r), .out_r_clamped(out_r_clamped), .level(level), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_tol(input string nm, input logic [31:0] act, input logic [31:0] exp);
    int d;
    d = (act > exp) ? int'(act - exp) : int'(exp - act);
    n_cmp++;
    if ($isunknown(act) || d > 2) begin
      n_err++;
      $display("FAIL %s: got %h expected %h +-2", nm, act, exp);
    end
  endtask

  // model: turn = floor(a * (1/2pi in Q0.32) / 2^32), saturating, with a lifted into [0, 2pi)
  function automatic logic [W-1:0] model_entry(input logic [64:0] ang, input logic [64:0] r);
    logic signed [66:0] a;
    logic [66:0]        prod;
    logic [31:0]        t;
    logic [64:0]        ro;
    logic               cl;
    a = $signed({{2{ang[64]}}, ang});
    if (a < 0) a = a + 67'sd26986075409;
    if (a < 0) a = 0;
    prod = 67'(a[34:0]) * 67'd683565276;
    t  = (prod >= (67'd1 << 64)) ? 32'hFFFFFFFF : prod[63:32];
    ro = r;
    cl = 1'b0;
`ifdef POLAR_MAPPER_RCLAMP_EN
    if ($signed(r) > $signed(R_MAX)) begin
      ro = R_MAX;
      cl = 1'b1;
    end
`endif
    return {t, ro, cl};
  endfunction

  // scoreboard: pending results land in the FIFO three edges after sampling
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pend_q[$];
  int           due_q[$];
  logic         m_ovf;
  int           cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete(); pend_q.delete(); due_q.delete();
      m_ovf = 1'b0;
      cyc   = 0;
    end else begin
      logic do_pop, drop;
      cyc++;
      do_pop = (exp_q.size() > 0) && out_ready;
      drop   = 1'b0;
      if (do_pop) void'(exp_q.pop_front());
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        logic [W-1:0] e;
        e = pend_q.pop_front();
        void'(due_q.pop_front());
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else drop = 1'b1;
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (drop)    m_ovf = 1'b1;
      if (in_valid) begin
        pend_q.push_back(model_entry(in_atan2, in_r));
        due_q.push_back(cyc + 3);
      end
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 65'(out_valid), 65'(exp_q.size() > 0));
      chk("level", 65'(level), 65'(exp_q.size()));
      chk("overflow", 65'(overflow), 65'(m_ovf));
      if (exp_q.size() > 0) begin
        logic [W-1:0] h;
        h = exp_q[0];
        chk("out_turn", 65'(out_turn), 65'(h[97:66]));
        chk("out_sector", 65'(out_sector), 65'(h[97:95]));
        chk("out_r", out_r, h[65:1]);
        chk("out_r_clamped", 65'(out_r_clamped), 65'(h[0]));
      end
    end
  end

  // driver tasks
  task automatic drive_cycle(input logic v, input logic [64:0] ang, input logic [64:0] r,
                             input logic rdy, input logic clr);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_atan2  = ang;
    in_r      = r;
    out_ready = rdy;
    ovf_clr   = clr;
  endtask

  task automatic run_one(input logic [64:0] ang, input logic [64:0] r,
                         output logic [31:0] t, output logic [2:0] s,
                         output logic [64:0] ro, output logic cl, output int lat);
    lat = 0;
    t = 'x; s = 'x; ro = 'x; cl = 1'bx;
    drive_cycle(1'b1, ang, r, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      if (out_valid && lat == 0) begin
        lat = i; t = out_turn; s = out_sector; ro = out_r; cl = out_r_clamped;
      end
    end
  endtask

  logic [64:0] ang_tab [4];
  logic [31:0] turn_tab[4];
  logic [2:0]  sec_tab [4];

  initial begin
    logic [31:0] t;
    logic [2:0]  s;
    logic [64:0] ro;
    logic        cl;
    int          lat, seen;

    rst_n = 1'b0; in_valid = 1'b0; in_atan2 = '0; in_r = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst out_valid", 65'(out_valid), 65'd0);
    chk("rst level", 65'(level), 65'd0);
    chk("rst overflow", 65'(overflow), 65'd0);
    chk("rst out_turn", 65'(out_turn), 65'd0);
    chk("rst out_sector", 65'(out_sector), 65'd0);
    chk("rst out_r", out_r, 65'd0);
    chk("rst out_r_clamped", 65'(out_r_clamped), 65'd0);
    #1 rst_n = 1'b1;

    // angle -> turn/sector, with latency
    ang_tab[0] = 65'h0;          turn_tab[0] = 32'h00000000; sec_tab[0] = 3'd0;
    ang_tab[1] = 65'h1921FB544;  turn_tab[1] = 32'h40000000; sec_tab[1] = 3'd2;
    ang_tab[2] = 65'h3243F6A88;  turn_tab[2] = 32'h80000000; sec_tab[2] = 3'd4;
    ang_tab[3] = -65'h1921FB544; turn_tab[3] = 32'hC0000000; sec_tab[3] = 3'd6;
    for (int k = 0; k < 4; k++) begin
      run_one(ang_tab[k], R_3P5, t, s, ro, cl, lat);
      chk_tol($sformatf("turn[%0d]", k), t, turn_tab[k]);
      chk($sformatf("sector[%0d]", k), 65'(s), 65'(sec_tab[k]));
      chk($sformatf("latency[%0d]", k), 65'(lat), 65'd4);
    end

    // -pi - 2^-32 lifts to just under pi: no wrap to a tiny turn
    run_one(-65'h3243F6A89, R_3P5, t, s, ro, cl, lat);
    chk_tol("turn -pi-eps", t, 32'h80000000);
    // just above 2*pi saturates
    run_one(65'h6487ED611, R_3P5, t, s, ro, cl, lat);
    chk("turn sat", 65'(t), 65'hFFFFFFFF);
    chk("sector sat", 65'(s), 65'd7);
    run_one(65'h7_00000000, R_3P5, t, s, ro, cl, lat);
    chk("turn 7.0", 65'(t), 65'hFFFFFFFF);
    // -7.0 + 2pi is still negative -> 0
    run_one(-65'h7_00000000, R_3P5, t, s, ro, cl, lat);
    chk("turn -7.0", 65'(t), 65'd0);

    // radius handling
    run_one(65'h0, R_20, t, s, ro, cl, lat);
`ifdef POLAR_MAPPER_RCLAMP_EN
    chk("r 20 clamp", ro, R_MAX);
    chk("r 20 flag", 65'(cl), 65'd1);
`else
    chk("r 20 raw", ro, R_20);
    chk("r 20 flag", 65'(cl), 65'd0);
`endif
    run_one(65'h0, R_3P5, t, s, ro, cl, lat);
    chk("r 3.5", ro, R_3P5);
    chk("r 3.5 flag", 65'(cl), 65'd0);

    // overflow: 5 pushes into a 4-deep FIFO with no drain
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 65'(i) << 30, 65'(i + 1) << 32, 1'b0, 1'b0);
    repeat (4) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("ovf level full", 65'(level), 65'd4);
    chk("ovf flag set", 65'(overflow), 65'd1);
    repeat (6) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("ovf drained level", 65'(level), 65'd0);
    chk("ovf still sticky", 65'(overflow), 65'd1);
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b1);
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("ovf cleared", 65'(overflow), 65'd0);

    // full FIFO, push coincides with pop: nothing dropped
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 65'(i + 3) << 29, 65'(i) << 31, 1'b0, 1'b0);
    repeat (2) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("simul level", 65'(level), 65'd4);
    chk("simul no ovf", 65'(overflow), 65'd0);
    repeat (6) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // reset with 2 buffered and 3 in flight
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 65'(i) << 31, R_3P5, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst out_valid", 65'(out_valid), 65'd0);
    chk("midrst level", 65'(level), 65'd0);
    chk("midrst out_turn", 65'(out_turn), 65'd0);
    chk("midrst out_r", out_r, 65'd0);
    chk("midrst overflow", 65'(overflow), 65'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
      if (out_valid) seen++;
    end
    chk("post-rst quiet", 65'(seen), 65'd0);
    run_one(65'h1921FB544, R_3P5, t, s, ro, cl, lat);
    chk("post-rst latency", 65'(lat), 65'd4);
    chk("post-rst sector", 65'(s), 65'd2);

    repeat (4) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/polar_sector_mapper.md
# polar_sector_mapper

Downstream consumer of the CORDIC arctan2/magnitude stage in the raymarching pipeline. Takes the non-backpressurable `(atan2, r, valid)` result stream and maps the angle to an unsigned turn fraction in [0,1) and a sector index, optionally clamping the radius. Results are buffered in a FIFO and drained through a valid/ready port toward the shading/texture stage.

## Interface
- `SECTOR_BITS`, 3: width of sector index; sectors = 2^SECTOR_BITS equal angular slices.
- `DEPTH`, 8: FIFO entries, power of two, ≥2.
- `R_MAX`, 65'd16<<32 (16.0): radius clamp limit, `fixedpoint::number`. Used only with the clamp macro.
- `clk`  in  1  clock, all logic posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream result valid; no backpressure, one result per high cycle.
- `in_atan2`  in  65  `fixedpoint::number` (signed, 32 frac bits), angle in approx. (-π, π].
- `in_r`  in  65  `fixedpoint::number`, magnitude, ≥0.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts head when `out_valid && out_ready`.
- `out_turn`  out  32  unsigned Q0.32 angle/2π.
- `out_sector`  out  SECTOR_BITS  `out_turn[31 -: SECTOR_BITS]`.
- `out_r`  out  65  radius (clamped or raw).
- `out_r_clamped`  out  1  radius was clamped.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky: a result was dropped.
- `ovf_clr`  in  1  synchronous clear of `overflow`.

## Operation
- S1 (registered): `a = in_atan2[64] ? in_atan2 + 2π : in_atan2`; 2π = 6 + 0x487ED511·2^-32. If result still negative, `a = 0`.
- S2 (registered): `p = a[34:0] × 0x28BE60DC` (1/2π, Q0.32), 67-bit unsigned product.
- S3 (registered): `turn = p[66:64] != 0 ? 32'hFFFFFFFF : p[63:32]`; sector from `turn`; radius handling per Configuration. S3 valid pushes into FIFO.
- Each stage carries its own valid bit; `in_r` travels alongside unchanged through S1/S2.
- FIFO: first-word-fall-through, entries in arrival order; `out_*` data reflect head whenever `out_valid`=1 and are held stable while `out_valid && !out_ready`.
- Push when full: if `out_ready && out_valid` same cycle, push accepted (simultaneous pop/push). Otherwise entry dropped, `overflow` set, FIFO unchanged.
- Empty: `out_valid`=0, data outputs hold last value (don't-care).
- `ovf_clr` and drop same cycle: `overflow` ends set (drop wins).
- Pointers wrap modulo DEPTH; `level` exact 0..DEPTH.

## Timing
- Reset (async assert, sync deassert handled upstream): all stage valids 0, FIFO empty, `level`=0, `out_valid`=0, `overflow`=0, `out_turn`=0, `out_sector`=0, `out_r`=0, `out_r_clamped`=0.
- Reset mid-operation: in-flight and buffered results discarded; no output after deassert until new `in_valid`.
- Latency: `in_valid` sampled at edge k → FIFO write at edge k+3 → `out_valid`=1 in cycle after edge k+3 (empty FIFO).
- Throughput: one result per clock; pipeline never stalls (upstream cannot be held).
- `level` updates on the edge of push/pop; sustained `out_ready`=1 keeps occupancy ≤1.

## Configuration
- `POLAR_MAPPER_RCLAMP_EN` defined: in S3 `out_r = (r > R_MAX) ? R_MAX : r` (signed compare), `out_r_clamped` = compare result.
- Not defined: `out_r = r` unchanged, `out_r_clamped` tied 0, `R_MAX` unused.

## Test plan
- `in_atan2`=0, 1.5707963 (π/2), 3.1415926 (π), -1.5707963 → `out_turn` = 0x00000000, 0x40000000, 0x80000000, 0xC0000000 each ±2 LSB; `out_sector` (SECTOR_BITS=3) = 0, 2, 4, 6; each `out_valid` 4 edges after input.
- `in_atan2` = -π - 2^-32 → `out_turn` ≈ 0xFFFFFFFF/0x7FFFFFFF-region without going negative (no wrap to small negative), saturation path exercised with `a`≈2π+ε → 0xFFFFFFFF.
- DEPTH=4, `out_ready`=0, 5 consecutive `in_valid` → `level`=4, `overflow`=1, 5th dropped; then `out_ready`=1 → 4 results in order, `level`→0; `ovf_clr` pulse → `overflow`=0.
- FIFO full, `out_ready`=1 and push same cycle → no drop, `overflow` stays 0, `level` stays 4.
- With macro, R_MAX=16.0: `in_r`=20.0 → `out_r`=16.0, `out_r_clamped`=1; `in_r`=3.5 → 3.5, flag 0. Without macro: 20.0 → 20.0, flag 0.
- Assert `rst_n`=0 with 3 in flight and 2 buffered → all outputs 0 immediately; after release, no `out_valid` until new input.
